// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the round-robin arbiter and the FIFO.
// Handshake: a requester holds req_i/data_i/last_i stable; a word moves on any rising edge where ack_o is high.
interface fifo_wr_arbiter_if #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter int REQ_NUM   = 4,
  parameter int BURST_MAX = 4
);
  localparam int CW = $clog2(BURST_MAX + 1);

  logic [REQ_NUM-1:0]        req_i;
  logic [REQ_NUM*DWIDTH-1:0] data_i;
  logic [REQ_NUM-1:0]        last_i;
  logic [REQ_NUM-1:0]        ack_o;
  logic [REQ_NUM-1:0]        grant_o;
  logic                      wr_req_o;
  logic [DWIDTH-1:0]         wr_data_o;
  logic                      wr_full_i;
  logic [AWIDTH-1:0]         wr_usedw_i;
  logic                      busy_o;
  logic [CW-1:0]             beat_cnt_o;
  logic [AWIDTH-1:0]         status_usedw_o;

  modport slave (
    input  req_i, data_i, last_i, wr_full_i, wr_usedw_i,
    output ack_o, grant_o, wr_req_o, wr_data_o, busy_o, beat_cnt_o, status_usedw_o
  );

  modport master (
    output req_i, data_i, last_i, wr_full_i, wr_usedw_i,
    input  ack_o, grant_o, wr_req_o, wr_data_o, busy_o, beat_cnt_o, status_usedw_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the FIFO write port: one burst per grant, every beat gated by wr_full_i.
// busy_o is the FSM state (IDLE=0, BURST=1) and beat_cnt_o its burst progress.
module fifo_wr_arbiter #(
  parameter int DWIDTH    = 8,
  parameter int REQ_NUM   = 4,
  parameter int BURST_MAX = 4
) (
  input  logic               clk_i,
  input  logic               srst_i,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int IW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CW = $clog2(BURST_MAX + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [REQ_NUM-1:0] grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [CW-1:0]      beat_q, beat_d;

  logic [IW-1:0]      cand;
  logic [IW-1:0]      win;
  logic               found;
  logic               xfer;
  logic [REQ_NUM-1:0] ack;
  logic [DWIDTH-1:0]  wr_data;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    cand    = '0;
    win     = '0;
    found   = 1'b0;
    xfer    = 1'b0;
    ack     = '0;
    wr_data = '0;

    if (state_q == ST_IDLE) begin
      // Scan starts just after the previous winner so every requester gets a turn.
      for (int i = 1; i <= REQ_NUM; i++) begin
        cand = IW'((int'(rr_q) + i) % REQ_NUM);
        if (!found && bus.req_i[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
      if (found) begin
        grant_d      = '0;
        grant_d[win] = 1'b1;
        owner_d      = win;
        rr_d         = win;
        beat_d       = '0;
        state_d      = ST_BURST;
      end
    end else begin
      xfer         = bus.req_i[owner_q] & ~bus.wr_full_i;
      ack[owner_q] = xfer;
      wr_data      = bus.data_i[int'(owner_q)*DWIDTH +: DWIDTH];

      // A dropped request ends the burst even while the FIFO is full.
      if (!bus.req_i[owner_q]) begin
        state_d = ST_IDLE;
        grant_d = '0;
        beat_d  = '0;
      end else if (xfer) begin
        if (bus.last_i[owner_q] || (beat_q == CW'(BURST_MAX - 1))) begin
          state_d = ST_IDLE;
          grant_d = '0;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= IW'(REQ_NUM - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.ack_o          = ack;
  assign bus.wr_req_o       = xfer;
  assign bus.wr_data_o      = wr_data;
  assign bus.grant_o        = grant_q;
  assign bus.busy_o         = (state_q == ST_BURST);
  assign bus.beat_cnt_o     = beat_q;
  assign bus.status_usedw_o = bus.wr_usedw_i;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: requesters replay word lists, a cycle model predicts ownership and writes.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N  = 4;
  localparam int BM = 4;
  localparam int CW = $clog2(BM + 1);
  localparam int DEPTH = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW), .REQ_NUM(N), .BURST_MAX(BM)) bus ();

  fifo_wr_arbiter #(.DWIDTH(DW), .REQ_NUM(N), .BURST_MAX(BM)) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  // ---------------- requester sources ----------------
  logic [DW-1:0] mem   [N][DEPTH];
  bit            lastm [N][DEPTH];
  int            rd_ptr [N];
  int            wr_cnt [N];
  bit            en     [N];
  bit            drop   [N];
  bit            full_ctl;
  bit            rand_full;

  // ---------------- reference model / scoreboard ----------------
  int            m_owner;
  int            m_beats;
  int            m_rr;
  bit            m_xfer;
  logic [N-1:0]  req_s;
  logic [N-1:0]  last_s;
  bit            srst_s;
  int            grant_log[$];
  logic [DW-1:0] exp_q[$];
  int            wr_seen;
  int            checks;
  int            errors;

  task automatic load(input int k, input int n, input logic [DW-1:0] base, input int burst_len);
    for (int i = 0; i < n; i++) begin
      mem[k][wr_cnt[k]]   = base + DW'(i);
      lastm[k][wr_cnt[k]] = (burst_len > 0) && (((i + 1) % burst_len) == 0);
      wr_cnt[k]++;
    end
  endtask

  function automatic bit pending(input int k);
    return en[k] && !drop[k] && (rd_ptr[k] < wr_cnt[k]);
  endfunction

  function automatic bit pending_any();
    bit p = 1'b0;
    for (int k = 0; k < N; k++) p |= pending(k);
    return p;
  endfunction

  task automatic drive_inputs();
    logic [N-1:0]    rv = '0;
    logic [N-1:0]    lv = '0;
    logic [N*DW-1:0] dv = '0;
    for (int k = 0; k < N; k++) begin
      if (en[k] && rd_ptr[k] < wr_cnt[k]) begin
        rv[k]          = !drop[k];
        lv[k]          = lastm[k][rd_ptr[k]];
        dv[k*DW +: DW] = mem[k][rd_ptr[k]];
      end
    end
    bus.req_i      = rv;
    bus.last_i     = lv;
    bus.data_i     = dv;
    bus.wr_full_i  = full_ctl | (rand_full && ($urandom_range(0, 2) == 0));
    bus.wr_usedw_i = AW'($urandom_range(0, (1 << AW) - 1));
  endtask

  task automatic check_cycle();
    logic [N-1:0]  exp_grant = '0;
    logic [N-1:0]  exp_ack   = '0;
    logic [DW-1:0] exp_data  = '0;
    logic [DW-1:0] sb_word;
    req_s  = bus.req_i;
    last_s = bus.last_i;
    srst_s = srst;
    m_xfer = 1'b0;
    if (m_owner >= 0) begin
      exp_grant[m_owner] = 1'b1;
      m_xfer             = req_s[m_owner] && !bus.wr_full_i;
      exp_ack[m_owner]   = m_xfer;
      exp_data           = bus.data_i[m_owner*DW +: DW];
    end
    checks += 7;
    if (bus.grant_o !== exp_grant) begin
      errors++; $display("FAIL grant_o @%0t: got %b exp %b", $time, bus.grant_o, exp_grant);
    end
    if (bus.busy_o !== (m_owner >= 0)) begin
      errors++; $display("FAIL busy_o @%0t: got %b exp %b", $time, bus.busy_o, (m_owner >= 0));
    end
    if (bus.beat_cnt_o !== CW'(m_beats)) begin
      errors++; $display("FAIL beat_cnt_o @%0t: got %0d exp %0d", $time, bus.beat_cnt_o, m_beats);
    end
    if (bus.wr_req_o !== m_xfer) begin
      errors++; $display("FAIL wr_req_o @%0t: got %b exp %b", $time, bus.wr_req_o, m_xfer);
    end
    if (bus.ack_o !== exp_ack) begin
      errors++; $display("FAIL ack_o @%0t: got %b exp %b", $time, bus.ack_o, exp_ack);
    end
    if (bus.wr_data_o !== exp_data) begin
      errors++; $display("FAIL wr_data_o @%0t: got %h exp %h", $time, bus.wr_data_o, exp_data);
    end
    if (bus.status_usedw_o !== bus.wr_usedw_i) begin
      errors++; $display("FAIL status_usedw @%0t: got %h exp %h", $time, bus.status_usedw_o, bus.wr_usedw_i);
    end
    if (m_xfer) exp_q.push_back(exp_data);
    if (bus.wr_req_o === 1'b1) begin
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL fifo_word @%0t: got %h exp none", $time, bus.wr_data_o);
      end else begin
        sb_word = exp_q.pop_front();
        if (bus.wr_data_o !== sb_word) begin
          errors++; $display("FAIL fifo_word @%0t: got %h exp %h", $time, bus.wr_data_o, sb_word);
        end
      end
    end
  endtask

  task automatic update_model();
    if (m_xfer) rd_ptr[m_owner]++;
    if (srst_s) begin
      m_owner = -1; m_beats = 0; m_rr = N - 1;
    end else if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        if (m_owner < 0 && req_s[(m_rr + i) % N]) m_owner = (m_rr + i) % N;
      end
      if (m_owner >= 0) begin
        m_rr = m_owner; m_beats = 0; grant_log.push_back(m_owner);
      end
    end else if (!req_s[m_owner]) begin
      m_owner = -1; m_beats = 0;
    end else if (m_xfer) begin
      if (last_s[m_owner] || (m_beats + 1 == BM)) begin
        m_owner = -1; m_beats = 0;
      end else begin
        m_beats++;
      end
    end
  endtask

  task automatic step();
    drive_inputs();
    #3;
    check_cycle();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic run_until_idle(input int max_cycles, input string tag);
    int n = 0;
    while (n < max_cycles && (m_owner >= 0 || pending_any())) begin
      step(); n++;
    end
    checks++;
    if (m_owner >= 0 || pending_any()) begin
      errors++; $display("FAIL %s_drain: still busy after %0d cycles, exp idle", tag, n);
    end
  endtask

  task automatic clear_en();
    for (int k = 0; k < N; k++) begin en[k] = 1'b0; drop[k] = 1'b0; end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    srst = 1'b1;
    repeat (2) step();
    srst = 1'b0;
  endtask

  task automatic test_single_burst();
    int w0 = wr_seen;
    clear_en(); grant_log.delete();
    load(1, 3, 8'hA1, 3);
    en[1] = 1'b1;
    run_until_idle(20, "single");
    checks += 2;
    if (grant_log.size() != 1 || grant_log[0] != 1) begin
      errors++; $display("FAIL single_grant: got %0d grants exp one to requester 1", grant_log.size());
    end
    if (wr_seen - w0 != 3) begin
      errors++; $display("FAIL single_writes: got %0d exp 3", wr_seen - w0);
    end
  endtask

  task automatic test_round_robin();
    int w0;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    clear_en();
    srst = 1'b1; step(); srst = 1'b0;
    grant_log.delete();
    w0 = wr_seen;
    for (int k = 0; k < N; k++) begin
      load(k, 4, DW'(8'h10 * (k + 1)), 2);
      en[k] = 1'b1;
    end
    run_until_idle(80, "rr");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= grant_log.size() || grant_log[i] != exp_order[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d exp %0d", i, (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
      end
    end
    checks++;
    if (wr_seen - w0 != 16) begin
      errors++; $display("FAIL rr_writes: got %0d exp 16", wr_seen - w0);
    end
  endtask

  task automatic test_burst_max();
    int w0 = wr_seen;
    clear_en(); grant_log.delete();
    load(2, 6, 8'hC1, 0);
    en[2] = 1'b1;
    run_until_idle(30, "bmax");
    checks += 2;
    if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 2) begin
      errors++; $display("FAIL bmax_grants: got %0d grants exp two to requester 2", grant_log.size());
    end
    if (wr_seen - w0 != 6) begin
      errors++; $display("FAIL bmax_writes: got %0d exp 6", wr_seen - w0);
    end
  endtask

  task automatic test_full_stall();
    int w0 = wr_seen;
    clear_en(); grant_log.delete();
    load(0, 3, 8'h51, 3);
    en[0] = 1'b1;
    step();
    step();
    full_ctl = 1'b1;
    repeat (3) step();
    full_ctl = 1'b0;
    run_until_idle(20, "stall");
    checks += 2;
    if (grant_log.size() != 1 || grant_log[0] != 0) begin
      errors++; $display("FAIL stall_grants: got %0d grants exp one to requester 0", grant_log.size());
    end
    if (wr_seen - w0 != 3) begin
      errors++; $display("FAIL stall_writes: got %0d exp 3", wr_seen - w0);
    end
  endtask

  task automatic test_drop_full();
    int exp_order[3] = '{1, 2, 1};
    clear_en(); grant_log.delete();
    load(1, 4, 8'h71, 4);
    load(2, 2, 8'h81, 2);
    en[1] = 1'b1;
    step();
    step();
    en[2] = 1'b1; drop[1] = 1'b1; full_ctl = 1'b1;
    step();
    full_ctl = 1'b0;
    run_until_idle(30, "drop");
    drop[1] = 1'b0;
    run_until_idle(30, "drop_resume");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= grant_log.size() || grant_log[i] != exp_order[i]) begin
        errors++;
        $display("FAIL drop_order[%0d]: got %0d exp %0d", i, (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int exp_order[4] = '{2, 0, 2, 3};
    clear_en(); grant_log.delete();
    load(2, 4, 8'h91, 4);
    load(0, 2, 8'hB1, 2);
    load(3, 2, 8'hD1, 2);
    en[2] = 1'b1;
    step();
    step();
    srst = 1'b1; en[0] = 1'b1; en[3] = 1'b1;
    step();
    srst = 1'b0;
    checks++;
    if (bus.grant_o !== '0 || bus.busy_o !== 1'b0 || bus.beat_cnt_o !== '0 || bus.wr_req_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got grant=%b busy=%b beat=%0d wr_req=%b exp all zero",
               bus.grant_o, bus.busy_o, bus.beat_cnt_o, bus.wr_req_o);
    end
    run_until_idle(60, "mid_reset");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= grant_log.size() || grant_log[i] != exp_order[i]) begin
        errors++;
        $display("FAIL reset_order[%0d]: got %0d exp %0d", i, (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
      end
    end
  endtask

  task automatic test_random();
    int total;
    clear_en();
    rand_full = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (wr_cnt[k] - rd_ptr[k] < 4 && wr_cnt[k] < DEPTH - 8 && $urandom_range(0, 3) == 0) begin
          mem[k][wr_cnt[k]]   = DW'($urandom_range(0, 255));
          lastm[k][wr_cnt[k]] = ($urandom_range(0, 2) == 0);
          wr_cnt[k]++;
        end
        en[k]   = ($urandom_range(0, 7) != 0);
        drop[k] = ($urandom_range(0, 19) == 0);
      end
      srst = ($urandom_range(0, 199) == 0);
      step();
    end
    srst = 1'b0; rand_full = 1'b0;
    for (int k = 0; k < N; k++) begin en[k] = 1'b1; drop[k] = 1'b0; end
    run_until_idle(400, "random");
    total = 0;
    for (int k = 0; k < N; k++) total += wr_cnt[k];
    checks += 2;
    if (wr_seen != total) begin
      errors++; $display("FAIL no_loss: got %0d writes exp %0d words", wr_seen, total);
    end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover: got %0d unwritten words exp 0", exp_q.size());
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    checks = 0; errors = 0; wr_seen = 0;
    full_ctl = 1'b0; rand_full = 1'b0;
    for (int k = 0; k < N; k++) begin
      rd_ptr[k] = 0; wr_cnt[k] = 0; en[k] = 1'b0; drop[k] = 1'b0;
    end
    bus.req_i = '0; bus.last_i = '0; bus.data_i = '0;
    bus.wr_full_i = 1'b0; bus.wr_usedw_i = '0;
    m_owner = -1; m_beats = 0; m_rr = N - 1; m_xfer = 1'b0;
    srst = 1'b1;
    @(posedge clk);
    #1;

    test_reset();
    test_single_burst();
    test_round_robin();
    test_burst_max();
    test_full_stall();
    test_drop_full();
    test_reset_mid_burst();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
